// File: rtl/board_write_sched.sv
// rtl/board_write_sched.sv - serialises board-RAM token writes onto the drawing engine
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   req_valid/req_ready      placement request handshake (req_slot, req_tok)
//   clear_req                pulse requesting a full-board clear sweep
//   eng_start/eng_busy       drawing engine job handshake (eng_slot, eng_tok)
//   idle                     scheduler quiescent: no job, FIFO empty, no clear pending
//   clear_done               pulse when the last clear job has completed
module board_write_sched #(
    parameter int         SLOTS      = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] CLEAR_TOK  = 2'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [$clog2(SLOTS)-1:0] req_slot,
    input  logic [1:0]               req_tok,
    output logic                     req_ready,
    input  logic                     clear_req,
    output logic                     eng_start,
    output logic [$clog2(SLOTS)-1:0] eng_slot,
    output logic [1:0]               eng_tok,
    input  logic                     eng_busy,
    output logic                     idle,
    output logic                     clear_done
);
    localparam int SW = $clog2(SLOTS);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t        state;
    logic          pending;
    logic          sweep;

    // Request FIFO; pointers carry an extra wrap bit to tell full from empty.
    logic [SW+1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [SW+1:0] head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    // req_ready depends only on the registered pointers, never on this cycle's pop.
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    // A pending clear outranks queued requests, so the FIFO only pops when none is pending.
    assign pop        = (state == S_IDLE) && !pending && !fifo_empty;

    assign idle       = (state == S_IDLE) && fifo_empty && !pending;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {req_slot, req_tok};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pending    <= 1'b0;
            sweep      <= 1'b0;
            eng_start  <= 1'b0;
            eng_slot   <= '0;
            eng_tok    <= '0;
            clear_done <= 1'b0;
        end else begin
            eng_start  <= 1'b0;
            clear_done <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // A clear arriving mid-sweep is dropped: the running sweep already covers it.
            if (clear_req && !sweep) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pending) begin
                        eng_slot  <= '0;
                        eng_tok   <= CLEAR_TOK;
                        sweep     <= 1'b1;
                        eng_start <= 1'b1;
                        state     <= S_ISSUE;
                    end else if (!fifo_empty) begin
                        eng_slot  <= head[SW+1:2];
                        eng_tok   <= head[1:0];
                        eng_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (eng_busy) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!eng_busy) begin
                        if (sweep) begin
                            if (eng_slot == SW'(SLOTS - 1)) begin
                                clear_done <= 1'b1;
                                sweep      <= 1'b0;
                                pending    <= 1'b0;
                                state      <= S_IDLE;
                            end else begin
                                // Sweep continues without passing through IDLE.
                                eng_slot  <= eng_slot + 1'b1;
                                eng_start <= 1'b1;
                                state     <= S_ISSUE;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_board_write_sched.sv
// tb/tb_board_write_sched.sv - scoreboard bench for board_write_sched
module tb_board_write_sched;
    localparam int         SLOTS = 16;
    localparam logic [1:0] CLR   = 2'd0;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_slot;
    logic [1:0] req_tok;
    logic       req_ready;
    logic       clear_req;
    logic       eng_start;
    logic [3:0] eng_slot;
    logic [1:0] eng_tok;
    logic       eng_busy;
    logic       idle;
    logic       clear_done;

    board_write_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_slot   (req_slot),
        .req_tok    (req_tok),
        .req_ready  (req_ready),
        .clear_req  (clear_req),
        .eng_start  (eng_start),
        .eng_slot   (eng_slot),
        .eng_tok    (eng_tok),
        .eng_busy   (eng_busy),
        .idle       (idle),
        .clear_done (clear_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [5:0] req_q [$];
    bit         model_pending = 0;
    bit         model_sweep   = 0;
    int         sweep_slot    = 0;
    int         sweeps        = 0;
    int         dones         = 0;
    int         starts        = 0;
    int         cyc           = 0;
    int         last_start_cyc = 0;
    int         acc_cyc       = 0;

    // Engine behaviour
    int         dur  = 1;
    bit         hold = 0;
    int         eng_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Engine: busy rises the cycle after it samples eng_start, lasts dur cycles (or while hold).
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_busy <= 1'b0;
            eng_cnt  <= 0;
        end else if (!eng_busy && eng_start) begin
            eng_busy <= 1'b1;
            eng_cnt  <= dur;
        end else if (eng_busy && !hold) begin
            if (eng_cnt <= 1) eng_busy <= 1'b0;
            else eng_cnt <= eng_cnt - 1;
        end
    end

    // Monitor: samples 2 time units after each rising edge.
    bit         prev_start = 0;
    bit         b1 = 0;
    bit         b2 = 0;
    logic [5:0] cur = '0;
    always begin
        @(posedge clk);
        #2;
        if (!rst) begin
            prev_start = 0;
            b1 = 0;
            b2 = 0;
        end else begin
            cyc++;
            if (eng_start) begin
                logic [5:0] exp;
                bit         has_exp;
                has_exp = 1;
                exp     = '0;
                chk("start_not_consecutive", prev_start, 0);
                chk("start_while_busy", eng_busy, 0);
                starts++;
                last_start_cyc = cyc;
                if (model_sweep && sweep_slot < SLOTS) begin
                    exp = {4'(sweep_slot), CLR};
                    chk("sweep_restart_gap", {b2, b1}, 2'b10);
                    sweep_slot++;
                end else if (model_pending && !model_sweep) begin
                    model_sweep = 1;
                    sweep_slot  = 1;
                    sweeps++;
                    exp = {4'd0, CLR};
                end else if (req_q.size() > 0) begin
                    exp = req_q.pop_front();
                end else begin
                    has_exp = 0;
                    chk("unexpected_start", 1, 0);
                end
                if (has_exp) begin
                    chk("job_slot_tok", {eng_slot, eng_tok}, exp);
                    cur = exp;
                end
            end else if (eng_busy) begin
                chk("job_stable", {eng_slot, eng_tok}, cur);
            end
            if (clear_done) begin
                chk("clear_done_after_last", (model_sweep && sweep_slot == SLOTS), 1);
                chk("clear_done_gap", {b2, b1}, 2'b10);
                dones++;
                model_sweep   = 0;
                model_pending = 0;
            end
            prev_start = eng_start;
            b2 = b1;
            b1 = eng_busy;
        end
    end

    // Stimulus tasks: entered and left on a falling edge.
    task automatic push(input logic [3:0] s, input logic [1:0] t);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_slot  = s;
        req_tok   = t;
        #1;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            chk("push_timeout", 0, 1);
        end else begin
            req_q.push_back({s, t});
            acc_cyc = cyc + 1;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_clear();
        int n;
        n = 0;
        while (!(eng_busy || idle) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!(eng_busy || idle)) begin
            chk("clear_wait_timeout", 0, 1);
        end else begin
            clear_req = 1'b1;
            if (!model_sweep) model_pending = 1;
            @(negedge clk);
            clear_req = 1'b0;
        end
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!eng_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_busy", eng_busy, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(req_q.size() == 0 && !model_pending && !model_sweep && idle && !eng_busy)
               && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", (req_q.size() == 0 && !model_pending && !model_sweep && idle && !eng_busy), 1);
    endtask

    initial begin
        int s0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_slot  = '0;
        req_tok   = '0;
        clear_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_slot", eng_slot, 0);
        chk("rst_eng_tok", eng_tok, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_idle", idle, 1);
        @(negedge clk);

        // Single request
        dur = 2;
        push(4'd5, 2'd3);
        wait_drain();
        chk("single_starts", starts, 1);
        chk("single_latency", last_start_cyc - acc_cyc, 1);
        chk("single_idle", idle, 1);

        // Back-pressure with stalled engine
        hold = 1;
        push(4'd1, 2'd1);
        wait_busy();
        push(4'd2, 2'd2);
        push(4'd3, 2'd3);
        push(4'd4, 2'd0);
        push(4'd6, 2'd1);
        chk("full_ready_low", req_ready, 0);
        fork
            push(4'd7, 2'd2);
            begin
                repeat (6) @(negedge clk);
                chk("held_while_full", req_ready, 0);
                hold = 0;
            end
        join
        wait_drain();

        // Clear from idle
        dur = 1;
        s0 = starts;
        do_clear();
        wait_drain();
        chk("clear_job_count", starts - s0, SLOTS);
        chk("clear_idle_after", idle, 1);
        chk("clear_dones", dones, sweeps);

        // Clear during a FIFO job with 2 queued, plus a mid-sweep clear
        hold = 1;
        s0 = starts;
        push(4'd9, 2'd1);
        wait_busy();
        push(4'd10, 2'd2);
        push(4'd11, 2'd3);
        do_clear();
        hold = 0;
        begin
            int n;
            n = 0;
            while (!(model_sweep && sweep_slot >= 5) && n < 500) begin
                @(negedge clk);
                n++;
            end
        end
        do_clear();
        wait_drain();
        chk("mid_clear_job_count", starts - s0, SLOTS + 3);
        chk("mid_clear_dones", dones, sweeps);

        // Reset during WAIT_DONE with 3 entries queued
        hold = 1;
        push(4'd12, 2'd1);
        wait_busy();
        push(4'd13, 2'd2);
        push(4'd14, 2'd3);
        push(4'd15, 2'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_eng_start", eng_start, 0);
        chk("mrst_eng_slot", eng_slot, 0);
        chk("mrst_eng_tok", eng_tok, 0);
        chk("mrst_clear_done", clear_done, 0);
        chk("mrst_req_ready", req_ready, 1);
        chk("mrst_idle", idle, 1);
        req_q.delete();
        model_pending = 0;
        model_sweep   = 0;
        hold = 0;
        @(negedge clk);
        rst = 1'b1;
        s0 = starts;
        repeat (20) @(negedge clk);
        chk("no_start_after_reset", starts, s0);
        chk("idle_after_reset", idle, 1);

        // Randomised traffic
        for (int i = 0; i < 200; i++) begin
            int r;
            dur = $urandom_range(1, 4);
            r   = $urandom_range(0, 19);
            if (r == 0) begin
                do_clear();
            end else if (r < 14) begin
                push(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            end else begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end
        wait_drain();
        chk("final_dones", dones, sweeps);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
